// File: rtl/aud_pkg.sv
// Shared types and constants for the audio codec bring-up path: sequencer states,
// configuration word layout and the default codec bus address.
package aud_pkg;

  localparam logic [6:0]  CodecDevAddr = 7'h1A;
  localparam int unsigned RegAddrWidth = 7;
  localparam int unsigned RegDataWidth = 9;
  localparam int unsigned CfgWordWidth = RegAddrWidth + RegDataWidth;

  typedef logic [CfgWordWidth-1:0] cfg_word_t;

  typedef enum logic [2:0] {
    StIdle,
    StWaitReady,
    StSendB0,
    StSendB1,
    StWaitStop,
    StGap,
    StDone,
    StError
  } seq_state_e;

  // Codec registers take a 7-bit address and 9-bit data packed into two bus bytes.
  function automatic cfg_word_t cfg_word(input logic [RegAddrWidth-1:0] addr,
                                         input logic [RegDataWidth-1:0] data);
    return {addr, data};
  endfunction

endpackage

// File: rtl/codec_cfg_rom.sv
// Combinational init table for the audio codec; entries at or beyond NUM_REGS read as zero.
module codec_cfg_rom
  import aud_pkg::*;
#(
  parameter int unsigned NUM_REGS = 10
) (
  input  logic [3:0]  index,
  output logic [15:0] word
);

  cfg_word_t entry;

  always_comb begin
    entry = '0;
    case (index)
      4'd0:    entry = cfg_word(7'h0F, 9'h000); // soft reset
      4'd1:    entry = cfg_word(7'h06, 9'h010); // power down: all up except out
      4'd2:    entry = cfg_word(7'h00, 9'h017); // left line in, 0 dB
      4'd3:    entry = cfg_word(7'h01, 9'h017); // right line in, 0 dB
      4'd4:    entry = cfg_word(7'h02, 9'h079); // left headphone, 0 dB
      4'd5:    entry = cfg_word(7'h03, 9'h079); // right headphone, 0 dB
      4'd6:    entry = cfg_word(7'h04, 9'h012); // analog path: DAC select
      4'd7:    entry = cfg_word(7'h05, 9'h000); // digital path: unmute
      4'd8:    entry = cfg_word(7'h07, 9'h002); // I2S, 16-bit
      4'd9:    entry = cfg_word(7'h09, 9'h001); // activate
      default: entry = '0;
    endcase
    word = ({28'd0, index} < NUM_REGS) ? entry : '0;
  end

endmodule

// File: rtl/codec_init_sequencer.sv
// Walks the codec init table, issuing one two-byte write per entry through a byte-level
// I2C controller, with an idle gap between writes and a per-transaction timeout.
module codec_init_sequencer
  import aud_pkg::*;
#(
  parameter logic [6:0]  DEV_ADDR       = CodecDevAddr,
  parameter int unsigned NUM_REGS       = 10,
  parameter int unsigned GAP_CYCLES     = 16,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       i2c_ready,
  input  logic       i2c_write_in_progress,
  output logic       i2c_enable,
  output logic       i2c_mode,
  output logic [6:0] i2c_addr,
  output logic [7:0] i2c_byte,
  output logic       busy,
  output logic       done,
  output logic       error,
  output logic [3:0] reg_index
);

  localparam logic [3:0]  LastIdx      = 4'(NUM_REGS - 1);
  localparam logic [7:0]  GapLast      = 8'(GAP_CYCLES - 1);
  localparam logic [15:0] TimeoutLimit = 16'(TIMEOUT_CYCLES);

  seq_state_e  state_q, state_d;
  logic        start_q, wip_q;
  logic [15:0] tmo_q, tmo_d, tmo_inc;
  logic [7:0]  gap_q, gap_d;
  logic        enable_q, enable_d;
  logic [7:0]  byte_q, byte_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        error_q, error_d;
  logic [3:0]  idx_q, idx_d;

  logic        start_rise, wip_rise, timed_out;
  logic [15:0] rom_word;
  logic [7:0]  byte0, byte1;

  codec_cfg_rom #(
    .NUM_REGS(NUM_REGS)
  ) u_rom (
    .index(idx_q),
    .word (rom_word)
  );

  assign byte0      = rom_word[15:8];
  assign byte1      = rom_word[7:0];
  assign start_rise = start & ~start_q;
  assign wip_rise   = i2c_write_in_progress & ~wip_q;
  assign timed_out  = (tmo_q >= TimeoutLimit);
  assign tmo_inc    = (tmo_q == 16'hFFFF) ? tmo_q : tmo_q + 16'd1;

  always_comb begin
    state_d  = state_q;
    tmo_d    = '0;
    gap_d    = '0;
    enable_d = enable_q;
    byte_d   = byte_q;
    busy_d   = busy_q;
    done_d   = done_q;
    error_d  = error_q;
    idx_d    = idx_q;

    unique case (state_q)
      StIdle, StDone, StError: begin
        if (start_rise) begin
          state_d = StWaitReady;
          idx_d   = '0;
          done_d  = 1'b0;
          error_d = 1'b0;
          busy_d  = 1'b1;
        end
      end
      StWaitReady: begin
        tmo_d = tmo_inc;
        if (i2c_ready) begin
          enable_d = 1'b1;
          byte_d   = byte0;
          state_d  = StSendB0;
        end else if (timed_out) begin
          state_d = StError;
        end
      end
      StSendB0: begin
        tmo_d    = tmo_inc;
        enable_d = 1'b1;
        byte_d   = byte0;
        // The controller latched byte0 on this edge, so byte1 must be staged now.
        if (wip_rise) begin
          byte_d  = byte1;
          state_d = StSendB1;
        end else if (timed_out) begin
          state_d = StError;
        end
      end
      StSendB1: begin
        tmo_d  = tmo_inc;
        byte_d = byte1;
        if (wip_rise) begin
          enable_d = 1'b0;
          state_d  = StWaitStop;
        end else if (timed_out) begin
          state_d = StError;
        end
      end
      StWaitStop: begin
        tmo_d = tmo_inc;
        if (i2c_ready) begin
          if (idx_q < LastIdx) begin
            state_d = StGap;
          end else begin
            state_d = StDone;
            done_d  = 1'b1;
            busy_d  = 1'b0;
          end
        end else if (timed_out) begin
          state_d = StError;
        end
      end
      StGap: begin
        gap_d = gap_q + 8'd1;
        if (gap_q == GapLast) begin
          gap_d   = '0;
          idx_d   = idx_q + 4'd1;
          state_d = StWaitReady;
        end
      end
      default: state_d = StIdle;
    endcase

    if (state_d == StError && state_q != StError) begin
      error_d  = 1'b1;
      busy_d   = 1'b0;
      enable_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      start_q  <= 1'b0;
      wip_q    <= 1'b0;
      tmo_q    <= '0;
      gap_q    <= '0;
      enable_q <= 1'b0;
      byte_q   <= 8'h00;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      error_q  <= 1'b0;
      idx_q    <= '0;
    end else begin
      state_q  <= state_d;
      start_q  <= start;
      wip_q    <= i2c_write_in_progress;
      tmo_q    <= tmo_d;
      gap_q    <= gap_d;
      enable_q <= enable_d;
      byte_q   <= byte_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      error_q  <= error_d;
      idx_q    <= idx_d;
    end
  end

  assign i2c_enable = enable_q;
  assign i2c_mode   = 1'b1;
  assign i2c_addr   = DEV_ADDR;
  assign i2c_byte   = byte_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign error      = error_q;
  assign reg_index  = idx_q;

endmodule

// File: tb/tb_codec_init_sequencer.sv
// Scoreboard bench: a behavioral byte-level I2C controller feeds captured bytes to a monitor
// that compares them against hand-computed expectations queued by the stimulus.
module tb_codec_init_sequencer;

  localparam int unsigned Timeout = 4096;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start0 = 1'b0;
  logic start1 = 1'b0;
  logic ready = 1'b1;
  logic wip = 1'b0;
  logic hold_low = 1'b0;
  logic sel = 1'b0;

  logic       en0, mode0, busy0, done0, error0;
  logic [6:0] addr0;
  logic [7:0] byte0;
  logic [3:0] idx0;
  logic       en1, mode1, busy1, done1, error1;
  logic [6:0] addr1;
  logic [7:0] byte1;
  logic [3:0] idx1;

  always #5 clk = ~clk;

  codec_init_sequencer dut (
    .clk                  (clk),
    .reset                (reset),
    .start                (start0),
    .i2c_ready            (ready),
    .i2c_write_in_progress(wip),
    .i2c_enable           (en0),
    .i2c_mode             (mode0),
    .i2c_addr             (addr0),
    .i2c_byte             (byte0),
    .busy                 (busy0),
    .done                 (done0),
    .error                (error0),
    .reg_index            (idx0)
  );

  codec_init_sequencer #(
    .NUM_REGS      (1),
    .GAP_CYCLES    (1),
    .TIMEOUT_CYCLES(64)
  ) dut_one (
    .clk                  (clk),
    .reset                (reset),
    .start                (start1),
    .i2c_ready            (ready),
    .i2c_write_in_progress(wip),
    .i2c_enable           (en1),
    .i2c_mode             (mode1),
    .i2c_addr             (addr1),
    .i2c_byte             (byte1),
    .busy                 (busy1),
    .done                 (done1),
    .error                (error1),
    .reg_index            (idx1)
  );

  wire       en_m   = sel ? en1 : en0;
  wire [7:0] byte_m = sel ? byte1 : byte0;
  wire [3:0] idx_m  = sel ? idx1 : idx0;

  logic [7:0] exp_b0 [10] = '{8'h1E, 8'h0C, 8'h00, 8'h02, 8'h04, 8'h06, 8'h08, 8'h0A, 8'h0E, 8'h12};
  logic [7:0] exp_b1 [10] = '{8'h00, 8'h10, 8'h17, 8'h17, 8'h79, 8'h79, 8'h12, 8'h00, 8'h02, 8'h01};

  typedef struct packed {
    logic [7:0] b;
    logic [3:0] idx;
  } exp_t;
  exp_t exp_q[$];

  int n_pass = 0;
  int n_total = 0;
  int cyc = 0;
  int stop_cyc = 0;
  int cap_count = 0;
  logic       cap_valid = 1'b0;
  logic [7:0] cap_byte = 8'h00;
  logic [3:0] cap_idx = 4'h0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
  endtask

  task automatic push_byte(input logic [7:0] b, input logic [3:0] idx);
    exp_t e;
    e.b   = b;
    e.idx = idx;
    exp_q.push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_start(input bit which);
    if (which) start1 = 1'b1;
    else start0 = 1'b1;
    tick(1);
    start0 = 1'b0;
    start1 = 1'b0;
  endtask

  task automatic wait_done(input bit which, input int budget);
    int waited;
    waited = 0;
    while (!(which ? done1 : done0) && waited < budget) begin
      tick(1);
      waited++;
    end
    check("wait_done", 32'(which ? done1 : done0), 32'd1);
  endtask

  // Controller model: accepts on enable while ready, shifts bytes, stops when enable drops.
  initial begin : i2c_model
    int nbyte;
    bit more;
    forever begin
      tick(1);
      if (hold_low) begin
        ready = 1'b0;
      end else if (!ready) begin
        ready    = 1'b1;
        stop_cyc = cyc;
      end else if (en_m) begin
        ready = 1'b0;
        tick(3);
        nbyte = 0;
        do begin
          wip       = 1'b1;
          cap_byte  = byte_m;
          cap_idx   = idx_m;
          cap_valid = 1'b1;
          cap_count++;
          tick(1);
          wip       = 1'b0;
          cap_valid = 1'b0;
          tick(1);
          if (nbyte == 1) check("enable_fall_after_byte1", 32'(en_m), 32'd0);
          tick(5);
          nbyte++;
          more = en_m;
        end while (more && nbyte < 4);
        tick(1);
        ready    = 1'b1;
        stop_cyc = cyc;
      end
    end
  end

  always @(negedge clk) begin : monitor
    exp_t e;
    if (cap_valid) begin
      check("scoreboard_has_entry", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("byte", 32'(cap_byte), 32'(e.b));
        check("reg_index_at_byte", 32'(cap_idx), 32'(e.idx));
      end
    end
  end

  initial begin : watchdog
    repeat (30000) @(posedge clk);
    $display("FAIL watchdog: simulation exceeded cycle budget");
    $fatal(1);
  end

  initial begin : stimulus
    int n;
    int base;

    tick(3);
    reset = 1'b0;
    check("rst_enable", 32'(en0), 32'd0);
    check("rst_byte", 32'(byte0), 32'd0);
    check("rst_busy", 32'(busy0), 32'd0);
    check("rst_done", 32'(done0), 32'd0);
    check("rst_error", 32'(error0), 32'd0);
    check("rst_reg_index", 32'(idx0), 32'd0);
    check("mode", 32'(mode0), 32'd1);
    check("addr", 32'(addr0), 32'h1A);

    // Full sequence, with a stray start pulse while busy.
    for (int i = 0; i < 10; i++) begin
      push_byte(exp_b0[i], 4'(i));
      push_byte(exp_b1[i], 4'(i));
    end
    pulse_start(1'b0);
    check("busy_after_start", 32'(busy0), 32'd1);
    tick(100);
    pulse_start(1'b0);
    wait_done(1'b0, 2000);
    check("seq_busy", 32'(busy0), 32'd0);
    check("seq_error", 32'(error0), 32'd0);
    check("seq_reg_index", 32'(idx0), 32'd9);
    check("seq_enable", 32'(en0), 32'd0);
    check("seq_all_bytes_seen", 32'(exp_q.size()), 32'd0);

    // Controller never ready: timeout.
    hold_low = 1'b1;
    tick(3);
    pulse_start(1'b0);
    check("to_busy", 32'(busy0), 32'd1);
    check("to_done_cleared", 32'(done0), 32'd0);
    n = 0;
    while (!error0 && n < Timeout + 20) begin
      tick(1);
      n++;
    end
    check("to_latency", 32'(n), 32'(Timeout + 1));
    check("to_error", 32'(error0), 32'd1);
    check("to_enable", 32'(en0), 32'd0);
    check("to_done", 32'(done0), 32'd0);
    check("to_busy_low", 32'(busy0), 32'd0);

    // Reset during byte1 of entry 3.
    hold_low = 1'b0;
    tick(3);
    base = cap_count;
    for (int i = 0; i < 3; i++) begin
      push_byte(exp_b0[i], 4'(i));
      push_byte(exp_b1[i], 4'(i));
    end
    push_byte(exp_b0[3], 4'd3);
    pulse_start(1'b0);
    check("restart_error_cleared", 32'(error0), 32'd0);
    n = 0;
    while (cap_count < base + 7 && n < 1000) begin
      tick(1);
      n++;
    end
    check("reach_entry3_b0", 32'(cap_count - base), 32'd7);
    tick(2);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    check("mid_rst_enable", 32'(en0), 32'd0);
    check("mid_rst_byte", 32'(byte0), 32'd0);
    check("mid_rst_busy", 32'(busy0), 32'd0);
    check("mid_rst_done", 32'(done0), 32'd0);
    check("mid_rst_error", 32'(error0), 32'd0);
    check("mid_rst_reg_index", 32'(idx0), 32'd0);
    tick(30);
    check("mid_rst_no_extra_bytes", 32'(exp_q.size()), 32'd0);
    check("mid_rst_stays_idle", 32'(busy0), 32'd0);

    for (int i = 0; i < 10; i++) begin
      push_byte(exp_b0[i], 4'(i));
      push_byte(exp_b1[i], 4'(i));
    end
    pulse_start(1'b0);
    wait_done(1'b0, 2000);
    check("rerun_reg_index", 32'(idx0), 32'd9);
    check("rerun_all_bytes_seen", 32'(exp_q.size()), 32'd0);

    // Single-entry instance: straight to DONE after STOP.
    tick(3);
    sel = 1'b1;
    push_byte(8'h1E, 4'd0);
    push_byte(8'h00, 4'd0);
    pulse_start(1'b1);
    wait_done(1'b1, 500);
    check("one_done_after_stop", 32'(cyc - stop_cyc), 32'd1);
    check("one_busy", 32'(busy1), 32'd0);
    check("one_error", 32'(error1), 32'd0);
    check("one_reg_index", 32'(idx1), 32'd0);
    check("one_enable", 32'(en1), 32'd0);
    tick(10);
    check("one_all_bytes_seen", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/codec_init_sequencer.md
CODEC_INIT_SEQUENCER -- requirements
Module: codec_init_sequencer

Interface
REQ-001 Parameter DEV_ADDR, default 7'h1A: 7-bit I2C peripheral address of the audio codec.
REQ-002 Parameter NUM_REGS, default 10: number of register writes in the init table (range 1..16).
REQ-003 Parameter GAP_CYCLES, default 16: idle clk cycles between consecutive transactions (range 1..255).
REQ-004 Parameter TIMEOUT_CYCLES, default 4096: max clk cycles per transaction before error (range 64..65535).
REQ-005 clk  in  1  single system clock.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 start  in  1  level; rising edge (registered compare) begins the init sequence.
REQ-008 i2c_ready  in  1  I2C controller idle/ready flag.
REQ-009 i2c_write_in_progress  in  1  high while the I2C controller shifts out a data byte.
REQ-010 i2c_enable  out  1  transaction request and continue-writing request to the I2C controller.
REQ-011 i2c_mode  out  1  fixed 1 (write).
REQ-012 i2c_addr  out  7  equals DEV_ADDR.
REQ-013 i2c_byte  out  8  data byte presented to the I2C controller.
REQ-014 busy  out  1  high from accepted start until DONE or ERROR.
REQ-015 done  out  1  sticky; all NUM_REGS writes completed.
REQ-016 error  out  1  sticky; a transaction exceeded TIMEOUT_CYCLES.
REQ-017 reg_index  out  4  index of the table entry in progress or last completed.

Function
REQ-018 Each table entry is a 16-bit word {reg_addr[6:0], reg_data[8:0]}; byte0 = word[15:8], byte1 = word[7:0], sent in that order.
REQ-019 States: IDLE, WAIT_READY, SEND_B0, SEND_B1, WAIT_STOP, GAP, DONE, ERROR.
REQ-020 IDLE: on start rising edge, clear reg_index, done and error, set busy, go WAIT_READY; start while busy is ignored.
REQ-021 WAIT_READY: when i2c_ready=1, assert i2c_enable, drive byte0 and go SEND_B0.
REQ-022 SEND_B0: hold i2c_enable=1 and i2c_byte=byte0; on the first rising edge of i2c_write_in_progress, switch i2c_byte to byte1 in the same cycle, keep enable and go SEND_B1.
REQ-023 SEND_B1: hold i2c_byte=byte1; on the next rising edge of i2c_write_in_progress, deassert i2c_enable and go WAIT_STOP, so the controller issues STOP after byte1's ACK.
REQ-024 WAIT_STOP: on i2c_ready=1, go GAP if reg_index < NUM_REGS-1, else go DONE.
REQ-025 GAP: count GAP_CYCLES clk cycles with i2c_enable=0, increment reg_index by 1 on exit, and go WAIT_READY.
REQ-026 DONE: done=1, busy=0; a new start rising edge restarts from entry 0.
REQ-027 ERROR: entered from WAIT_READY, SEND_B0, SEND_B1 or WAIT_STOP when the per-transaction counter reaches TIMEOUT_CYCLES; error=1, busy=0, i2c_enable=0; a new start rising edge restarts from entry 0.
REQ-028 The timeout counter clears on entry to WAIT_READY, saturates and never wraps.
REQ-029 If timeout and a progress event (ready or write_in_progress edge) occur in the same cycle, progress wins.
REQ-030 Edge detectors on start and i2c_write_in_progress are single flops; the edge is valid one cycle after the input rises.
REQ-031 i2c_byte, i2c_enable, busy, done, error and reg_index are registered outputs; i2c_mode and i2c_addr are constants.
REQ-032 With NUM_REGS=1, one transaction runs and the sequencer goes straight from WAIT_STOP to DONE without a GAP.

Reset
REQ-033 reset asserted on a clk edge forces IDLE; i2c_enable=0, i2c_byte=8'h00, busy=0, done=0, error=0, reg_index=0, and all counters and edge flops clear.
REQ-034 Reset mid-transaction drops i2c_enable in the next cycle; no byte is re-presented until a new start edge.

Structure
REQ-035 State encoding, the table-word field widths and the default codec address belong in the shared package aud_pkg.
REQ-036 Init table is a combinational sub-module codec_cfg_rom (input index[3:0], output word[15:0]); entries beyond NUM_REGS return 16'h0000.

Verification
REQ-037 Reset, then pulse start with a behavioral I2C model -> NUM_REGS transactions; bytes observed per entry equal the codec_cfg_rom word split; done=1, busy=0, reg_index=NUM_REGS-1.
REQ-038 ROM entry 0 = 16'h1E00 (codec reset) -> first transaction carries bytes 8'h1E then 8'h00, and i2c_enable falls within 2 cycles of the second write_in_progress edge.
REQ-039 Model holds i2c_ready=0 forever -> error=1 after TIMEOUT_CYCLES+1 clk cycles from WAIT_READY entry, i2c_enable=0, done=0.
REQ-040 Assert reset during SEND_B1 of entry 3 -> next cycle all outputs are at reset values; a new start begins again at reg_index=0.
REQ-041 Pulse start again while busy -> sequence is unaffected and reg_index progression is monotonic.
REQ-042 GAP_CYCLES=1, NUM_REGS=1 -> one transaction, then DONE with no GAP state visited.
